// File: rtl/cpu_bus_tracer.sv
// cpu_bus_tracer
//
// Bus-cycle trace capture for the 6502 core. Sits beside the CPU on
// A_BUS/D_BUS/RW/SYNC and records each qualified bus cycle (cap_en=1) into a
// circular buffer, together with a free-running cycle stamp. An
// address/RW/SYNC trigger freezes the buffer after a programmable number of
// post-trigger entries. The frozen trace then drains oldest-first over a
// valid/ready port.
//
// Ports
//   clk            system clock, all state on the rising edge
//   RST            asynchronous active-low reset
//   cap_en         this clock is one bus cycle to sample
//   A_BUS/D_BUS    CPU address / data bus
//   RW, SYNC       CPU read(1)/write(0), opcode-fetch marker
//   arm, abort     control pulses (abort wins over arm)
//   trig_*         trigger compare value, bit mask, RW and SYNC qualifiers
//   post_count     entries captured after the trigger entry
//   state_o        0 IDLE, 1 ARMED, 2 POST, 3 DONE
//   overflow       pre-trigger entries were overwritten
//   fill           valid entries held in the buffer
//   trig_offset    readout index of the trigger entry
//   rd_valid/rd_ready/rd_data   readout port, rd_data = {stamp, RW, SYNC, addr, data}

module cpu_bus_tracer #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8,
    parameter int DEPTH  = 64,
    parameter int PTR_W  = 6,
    parameter int CYC_W  = 16
) (
    input  logic                              clk,
    input  logic                              RST,
    input  logic                              cap_en,
    input  logic [ADDR_W-1:0]                 A_BUS,
    input  logic [DATA_W-1:0]                 D_BUS,
    input  logic                              RW,
    input  logic                              SYNC,
    input  logic                              arm,
    input  logic                              abort,
    input  logic [ADDR_W-1:0]                 trig_addr,
    input  logic [ADDR_W-1:0]                 trig_mask,
    input  logic                              trig_rw,
    input  logic                              trig_rw_any,
    input  logic                              trig_sync_only,
    input  logic [PTR_W-1:0]                  post_count,
    output logic [1:0]                        state_o,
    output logic                              overflow,
    output logic [PTR_W:0]                    fill,
    output logic [PTR_W-1:0]                  trig_offset,
    output logic                              rd_valid,
    input  logic                              rd_ready,
    output logic [CYC_W+2+ADDR_W+DATA_W-1:0]  rd_data
);

    localparam int ENTRY_W = CYC_W + 2 + ADDR_W + DATA_W;
    localparam logic [PTR_W:0] FULL     = (PTR_W+1)'(DEPTH);
    // Largest post-trigger run that still leaves the trigger entry in the buffer.
    localparam logic [PTR_W:0] POST_MAX = (PTR_W+1)'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t              state_reg, state_next;
    logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next;
    logic [PTR_W-1:0]    rd_ptr_reg, rd_ptr_next;
    logic [PTR_W:0]      fill_reg, fill_next;
    logic [PTR_W:0]      rd_left_reg, rd_left_next;
    logic [PTR_W-1:0]    post_rem_reg, post_rem_next;
    logic [PTR_W-1:0]    trig_idx_reg, trig_idx_next;
    logic [PTR_W-1:0]    trig_off_reg, trig_off_next;
    logic [CYC_W-1:0]    stamp_reg, stamp_next;
    logic                overflow_reg, overflow_next;
    logic                rd_valid_reg, rd_valid_next;
    // Set on the edge that enters DONE so rd_valid rises one edge later.
    logic                rd_pend_reg, rd_pend_next;

    logic                mem_we;
    logic [ENTRY_W-1:0]  mem_wdata;
    logic [ENTRY_W-1:0]  mem [DEPTH];

    logic                trig_hit;
    logic                go_done;
    logic [PTR_W-1:0]    post_clamp;
    logic [PTR_W-1:0]    rd_start;

    assign trig_hit = (((A_BUS ^ trig_addr) & trig_mask) == '0)
                    && (trig_rw_any || (RW == trig_rw))
                    && (!trig_sync_only || SYNC);

    assign post_clamp = ({1'b0, post_count} > POST_MAX) ? POST_MAX[PTR_W-1:0] : post_count;

    // The stamp captured is the value before this edge's increment.
    assign mem_wdata = {stamp_reg, RW, SYNC, A_BUS, D_BUS};

    always_comb begin
        state_next    = state_reg;
        wr_ptr_next   = wr_ptr_reg;
        rd_ptr_next   = rd_ptr_reg;
        fill_next     = fill_reg;
        rd_left_next  = rd_left_reg;
        post_rem_next = post_rem_reg;
        trig_idx_next = trig_idx_reg;
        trig_off_next = trig_off_reg;
        overflow_next = overflow_reg;
        rd_valid_next = rd_valid_reg;
        rd_pend_next  = rd_pend_reg;
        stamp_next    = cap_en ? stamp_reg + 1'b1 : stamp_reg;
        mem_we        = 1'b0;
        go_done       = 1'b0;
        rd_start      = '0;

        if (abort) begin
            state_next    = IDLE;
            rd_valid_next = 1'b0;
            rd_pend_next  = 1'b0;
        end else if (arm && (state_reg == IDLE || state_reg == DONE)) begin
            state_next    = ARMED;
            wr_ptr_next   = '0;
            fill_next     = '0;
            overflow_next = 1'b0;
            rd_ptr_next   = '0;
            rd_valid_next = 1'b0;
            rd_pend_next  = 1'b0;
        end else begin
            case (state_reg)
                ARMED, POST: begin
                    if (cap_en) begin
                        mem_we      = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (fill_reg == FULL) begin
                            overflow_next = 1'b1;
                        end else begin
                            fill_next = fill_reg + 1'b1;
                        end
                        if (state_reg == ARMED) begin
                            if (trig_hit) begin
                                trig_idx_next = wr_ptr_reg;
                                post_rem_next = post_clamp;
                                if (post_clamp == '0) begin
                                    go_done = 1'b1;
                                end else begin
                                    state_next = POST;
                                end
                            end
                        end else begin
                            post_rem_next = post_rem_reg - 1'b1;
                            if (post_rem_reg == 1) begin
                                go_done = 1'b1;
                            end
                        end
                    end
                end
                DONE: begin
                    if (rd_pend_reg) begin
                        rd_valid_next = 1'b1;
                        rd_pend_next  = 1'b0;
                    end else if (rd_valid_reg && rd_ready) begin
                        rd_ptr_next  = rd_ptr_reg + 1'b1;
                        rd_left_next = rd_left_reg - 1'b1;
                        if (rd_left_reg == 1) begin
                            rd_valid_next = 1'b0;
                        end
                    end
                end
                default: ;
            endcase

            // Freeze: uses this edge's updated pointer/fill so the final write counts.
            if (go_done) begin
                state_next    = DONE;
                rd_pend_next  = 1'b1;
                rd_start      = (fill_next == FULL) ? wr_ptr_next : '0;
                rd_ptr_next   = rd_start;
                trig_off_next = trig_idx_next - rd_start;
                rd_left_next  = fill_next;
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            state_reg    <= IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            fill_reg     <= '0;
            rd_left_reg  <= '0;
            post_rem_reg <= '0;
            trig_idx_reg <= '0;
            trig_off_reg <= '0;
            stamp_reg    <= '0;
            overflow_reg <= 1'b0;
            rd_valid_reg <= 1'b0;
            rd_pend_reg  <= 1'b0;
        end else begin
            state_reg    <= state_next;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            fill_reg     <= fill_next;
            rd_left_reg  <= rd_left_next;
            post_rem_reg <= post_rem_next;
            trig_idx_reg <= trig_idx_next;
            trig_off_reg <= trig_off_next;
            stamp_reg    <= stamp_next;
            overflow_reg <= overflow_next;
            rd_valid_reg <= rd_valid_next;
            rd_pend_reg  <= rd_pend_next;
        end
    end

    // Trace storage has no reset; write enable is held off by the IDLE state.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[wr_ptr_reg] <= mem_wdata;
        end
    end

    assign rd_data     = mem[rd_ptr_reg];
    assign state_o     = state_reg;
    assign overflow    = overflow_reg;
    assign fill        = fill_reg;
    assign trig_offset = trig_off_reg;
    assign rd_valid    = rd_valid_reg;

endmodule

// File: tb/tb_cpu_bus_tracer.sv
// Testbench for cpu_bus_tracer (DEPTH=8). A behavioural model keeps the whole
// capture history in a queue; on freeze, the expected readout is simply the
// last min(n, DEPTH) captured entries. Outputs are compared on every falling edge.

module tb_cpu_bus_tracer;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int DEPTH  = 8;
    localparam int PTR_W  = 3;
    localparam int CYC_W  = 16;
    localparam int EW     = CYC_W + 2 + ADDR_W + DATA_W;

    logic              clk = 1'b0;
    logic              RST = 1'b0;
    logic              cap_en = 1'b0;
    logic [ADDR_W-1:0] A_BUS = '0;
    logic [DATA_W-1:0] D_BUS = '0;
    logic              RW = 1'b1;
    logic              SYNC = 1'b0;
    logic              arm = 1'b0;
    logic              abort = 1'b0;
    logic [ADDR_W-1:0] trig_addr = '0;
    logic [ADDR_W-1:0] trig_mask = '0;
    logic              trig_rw = 1'b0;
    logic              trig_rw_any = 1'b1;
    logic              trig_sync_only = 1'b0;
    logic [PTR_W-1:0]  post_count = '0;
    logic [1:0]        state_o;
    logic              overflow;
    logic [PTR_W:0]    fill;
    logic [PTR_W-1:0]  trig_offset;
    logic              rd_valid;
    logic              rd_ready = 1'b0;
    logic [EW-1:0]     rd_data;

    cpu_bus_tracer #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .PTR_W(PTR_W), .CYC_W(CYC_W)
    ) dut (
        .clk(clk), .RST(RST), .cap_en(cap_en), .A_BUS(A_BUS), .D_BUS(D_BUS),
        .RW(RW), .SYNC(SYNC), .arm(arm), .abort(abort),
        .trig_addr(trig_addr), .trig_mask(trig_mask), .trig_rw(trig_rw),
        .trig_rw_any(trig_rw_any), .trig_sync_only(trig_sync_only),
        .post_count(post_count), .state_o(state_o), .overflow(overflow),
        .fill(fill), .trig_offset(trig_offset), .rd_valid(rd_valid),
        .rd_ready(rd_ready), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int             m_state = 0;
    int             m_post_rem = 0;
    int             m_trig_pos = 0;
    int             m_trig_off = 0;
    int             m_idx = 0;
    bit             m_rd_valid = 1'b0;
    bit             m_pend = 1'b0;
    logic [CYC_W-1:0] m_stamp = '0;
    logic [EW-1:0]  m_trace[$];
    logic [EW-1:0]  m_view[$];
    logic [EW-1:0]  m_e;
    bit             m_hit;

    function automatic int m_fill();
        return (m_trace.size() > DEPTH) ? DEPTH : m_trace.size();
    endfunction

    task automatic m_finish();
        int n, k;
        n = m_trace.size();
        k = (n > DEPTH) ? DEPTH : n;
        m_view.delete();
        for (int i = n - k; i < n; i++) m_view.push_back(m_trace[i]);
        m_trig_off = m_trig_pos - (n - k);
        m_idx   = 0;
        m_state = 3;
        m_pend  = 1'b1;
    endtask

    always @(posedge clk or negedge RST) begin
        if (!RST) begin
            m_state = 0; m_post_rem = 0; m_trig_off = 0; m_idx = 0;
            m_rd_valid = 1'b0; m_pend = 1'b0; m_stamp = '0;
            m_trace.delete(); m_view.delete();
        end else begin
            m_e   = {m_stamp, RW, SYNC, A_BUS, D_BUS};
            m_hit = (((A_BUS ^ trig_addr) & trig_mask) == 0)
                    && (trig_rw_any || RW == trig_rw) && (!trig_sync_only || SYNC);
            if (abort) begin
                m_state = 0; m_rd_valid = 1'b0; m_pend = 1'b0;
            end else if (arm && (m_state == 0 || m_state == 3)) begin
                m_state = 1; m_trace.delete(); m_view.delete();
                m_rd_valid = 1'b0; m_pend = 1'b0; m_idx = 0;
            end else if (m_state == 1 && cap_en) begin
                m_trace.push_back(m_e);
                if (m_hit) begin
                    m_trig_pos = m_trace.size() - 1;
                    m_post_rem = (int'(post_count) > DEPTH - 1) ? DEPTH - 1 : int'(post_count);
                    if (m_post_rem == 0) m_finish();
                    else m_state = 2;
                end
            end else if (m_state == 2 && cap_en) begin
                m_trace.push_back(m_e);
                m_post_rem--;
                if (m_post_rem == 0) m_finish();
            end else if (m_state == 3) begin
                if (m_pend) begin
                    m_pend = 1'b0; m_rd_valid = 1'b1;
                end else if (m_rd_valid && rd_ready) begin
                    m_idx++;
                    if (m_idx == m_view.size()) m_rd_valid = 1'b0;
                end
            end
            if (cap_en) m_stamp = m_stamp + 1'b1;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (RST) begin
            check("state_o", state_o, m_state);
            check("fill", fill, m_fill());
            check("overflow", overflow, m_trace.size() > DEPTH);
            check("rd_valid", rd_valid, m_rd_valid);
            if (m_state == 3) check("trig_offset", trig_offset, m_trig_off);
            if (m_rd_valid && m_idx < m_view.size()) check("rd_data", rd_data, m_view[m_idx]);
        end
    end

    // ---------------- stimulus ----------------
    task automatic step(input logic ce, input logic [15:0] a, input logic [7:0] d,
                        input logic rw, input logic sy);
        cap_en = ce; A_BUS = a; D_BUS = d; RW = rw; SYNC = sy;
        @(negedge clk);
    endtask

    task automatic rstep();
        step(1'($urandom_range(0, 1)), 16'($urandom), 8'($urandom),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    endtask

    task automatic do_arm();
        arm = 1'b1; step(1'b1, 16'h1000, 8'h00, 1'b1, 1'b0); arm = 1'b0;
    endtask

    // mode 0: rd_ready toggles 1/0; mode 1: random
    task automatic drain(input int mode);
        int guard, nread;
        bit tog;
        guard = 0; nread = 0; tog = 1'b1;
        while (m_state == 3 && (m_pend || m_rd_valid) && guard < 200) begin
            rd_ready = (mode == 0) ? tog : 1'($urandom_range(0, 1));
            tog = !tog;
            if (rd_valid && rd_ready) begin
                nread++;
                $display("read  stamp=%0d rw=%0b sync=%0b addr=%h data=%h",
                         rd_data[41:26], rd_data[25], rd_data[24], rd_data[23:8], rd_data[7:0]);
            end
            rstep();
            guard++;
        end
        rd_ready = 1'b0;
        check("drain_in_time", guard < 200, 1);
        check("read_count", nread, m_view.size());
    endtask

    logic [15:0] pool  [4] = '{16'h0010, 16'h0011, 16'h8000, 16'hFFFC};
    logic [15:0] masks [4] = '{16'hFFFF, 16'hFF00, 16'hFFFE, 16'h0000};
    logic [CYC_W-1:0] arm_stamp;
    bit consec;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_state", state_o, 0);
        check("rst_fill", fill, 0);
        check("rst_overflow", overflow, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_trig_offset", trig_offset, 0);
        RST = 1'b1;
        repeat (2) step(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);

        // 1: trigger on 4th cycle, post 2, arm during POST ignored
        $display("scenario 1: trigger FFFC on 4th cycle, post_count=2");
        trig_addr = 16'hFFFC; trig_mask = 16'hFFFF; trig_rw_any = 1'b1;
        trig_sync_only = 1'b0; post_count = 3'd2;
        do_arm();
        step(1'b1, 16'h0200, 8'h11, 1'b1, 1'b1);
        step(1'b1, 16'h0201, 8'h22, 1'b1, 1'b0);
        step(1'b1, 16'h0202, 8'h33, 1'b0, 1'b0);
        step(1'b1, 16'hFFFC, 8'h44, 1'b1, 1'b0);
        check("s1_post", state_o, 2);
        arm = 1'b1; step(1'b1, 16'h0300, 8'h55, 1'b1, 1'b0); arm = 1'b0;
        check("s1_arm_ignored", state_o, 2);
        step(1'b1, 16'h0301, 8'h66, 1'b1, 1'b0);
        check("s1_done", state_o, 3);
        check("s1_fill", fill, 6);
        check("s1_trig_offset", trig_offset, 3);
        check("s1_model_len", m_view.size(), 6);
        check("s1_trig_addr", m_view[3][23:8], 16'hFFFC);
        consec = 1'b1;
        for (int i = 1; i < 6; i++)
            if (m_view[i][41:26] != m_view[i-1][41:26] + 16'd1) consec = 1'b0;
        check("s1_stamps_consecutive", consec, 1);
        drain(0);

        // 2: overflow, trigger on 13th cycle, post 3
        $display("scenario 2: 12 misses, trigger on 13th, post_count=3");
        post_count = 3'd3;
        do_arm();
        arm_stamp = m_stamp;
        for (int i = 0; i < 12; i++)
            step(1'b1, 16'($urandom_range(0, 16'hFFF0)), 8'($urandom), 1'b1, 1'b0);
        step(1'b1, 16'hFFFC, 8'hA0, 1'b0, 1'b1);
        repeat (3) step(1'b1, 16'h0400, 8'hB0, 1'b1, 1'b0);
        check("s2_done", state_o, 3);
        check("s2_fill", fill, 8);
        check("s2_overflow", overflow, 1);
        check("s2_trig_offset", trig_offset, 4);
        check("s2_first_stamp", m_view[0][41:26], arm_stamp + 16'd8);
        drain(1);

        // 3: masked address with SYNC qualifier, post_count=0
        $display("scenario 3: mask FF00 addr 8000 sync_only, post_count=0");
        trig_addr = 16'h8000; trig_mask = 16'hFF00; trig_sync_only = 1'b1; post_count = 3'd0;
        do_arm();
        step(1'b1, 16'h80A5, 8'h01, 1'b1, 1'b0);
        check("s3_nosync", state_o, 1);
        step(1'b1, 16'h7FA5, 8'h02, 1'b1, 1'b1);
        check("s3_wrong_addr", state_o, 1);
        step(1'b1, 16'h80A5, 8'h03, 1'b1, 1'b1);
        check("s3_done", state_o, 3);
        check("s3_fill", fill, 3);
        check("s3_trig_offset", trig_offset, 2);
        drain(0);

        // 4: maximum post count with gaps in cap_en, then abort in DONE
        $display("scenario 4: post_count=7 with cap_en gaps, abort in DONE");
        trig_addr = 16'h1234; trig_mask = 16'hFFFF; trig_sync_only = 1'b0;
        trig_rw_any = 1'b0; trig_rw = 1'b0; post_count = 3'd7;
        do_arm();
        step(1'b1, 16'h1234, 8'h10, 1'b1, 1'b0);
        check("s4_rw_miss", state_o, 1);
        step(1'b1, 16'h1234, 8'h20, 1'b0, 1'b0);
        for (int i = 0; i < 14; i++)
            step(1'(i % 2 == 0), 16'h0500 + 16'(i), 8'(i), 1'b1, 1'b0);
        check("s4_done", state_o, 3);
        check("s4_fill", fill, 8);
        check("s4_overflow", overflow, 1);
        check("s4_trig_offset", trig_offset, 0);
        check("s4_trig_entry", m_view[0][25:8], {1'b0, 1'b0, 16'h1234});
        check("s4_rd_valid", rd_valid, 1);
        abort = 1'b1; step(1'b0, 16'h0, 8'h0, 1'b1, 1'b0); abort = 1'b0;
        check("s4_abort_state", state_o, 0);
        check("s4_abort_rd_valid", rd_valid, 0);

        // 5: randomized rounds
        $display("scenario 5: randomized rounds");
        for (int r = 0; r < 30; r++) begin
            trig_addr = pool[$urandom_range(0, 3)];
            trig_mask = masks[$urandom_range(0, 3)];
            trig_rw = 1'($urandom_range(0, 1));
            trig_rw_any = 1'($urandom_range(0, 1));
            trig_sync_only = 1'($urandom_range(0, 1));
            post_count = 3'($urandom_range(0, 7));
            do_arm();
            for (int c = 0; c < 40 && m_state != 3; c++) begin
                abort = ($urandom_range(0, 49) == 0);
                arm   = ($urandom_range(0, 29) == 0);
                step(1'($urandom_range(0, 3) != 0), pool[$urandom_range(0, 3)] ^ 16'($urandom_range(0, 1)),
                     8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            end
            abort = 1'b0; arm = 1'b0;
            if (m_state == 3) begin
                $display("round %0d: frozen with %0d entries", r, m_view.size());
                drain(1);
            end else begin
                $display("round %0d: no trigger, aborting", r);
                abort = 1'b1; rstep(); abort = 1'b0;
            end
        end

        // 6: asynchronous reset during POST
        $display("scenario 6: reset during POST");
        abort = 1'b1; rstep(); abort = 1'b0;
        trig_addr = 16'h0042; trig_mask = 16'hFFFF; trig_rw_any = 1'b1;
        trig_sync_only = 1'b0; post_count = 3'd5;
        do_arm();
        step(1'b1, 16'h0042, 8'h77, 1'b1, 1'b0);
        step(1'b1, 16'h0043, 8'h78, 1'b1, 1'b0);
        check("s6_post", state_o, 2);
        #2 RST = 1'b0;
        #1;
        check("s6_rst_state", state_o, 0);
        check("s6_rst_fill", fill, 0);
        check("s6_rst_overflow", overflow, 0);
        check("s6_rst_rd_valid", rd_valid, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        RST = 1'b1;
        step(1'b1, 16'h0000, 8'h00, 1'b1, 1'b0);
        check("s6_after_rst", state_o, 0);
        trig_mask = 16'h0000; post_count = 3'd0;
        do_arm();
        step(1'b1, 16'h0099, 8'h99, 1'b0, 1'b1);
        check("s6_retrigger", state_o, 3);
        drain(0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

endmodule
